drum_tap_streamer: RTL and testbench
====================================

// Module: drum_tap_streamer
// PURPOSE
//  Downstream of the node-patch grid. Samples one tap node of u_2_mid each time the grid's iterFlag signals
//  a completed time step, converts it to a 16-bit audio word, buffers it, and streams it to the audio
//  output path over a valid/ready handshake. Also counts steps, stops after a programmed sample count,
//  and flags dropped samples.
// PARAMETERS
//  SIZE        4   grid edge length; must match the grid instance
//  FIFO_DEPTH  8   sample buffer depth (power of 2, >=2)
//  CNT_W       16  width of num_samples / sample_count
// PORTS
//  clock         in   1              single clock, all logic rising-edge
//  reset         in   1              asynchronous, active-high; clears all state
//  u_2_mid       in   18s x SIZE^2   grid output, unpacked [SIZE-1:0][SIZE-1:0], signed 1.17
//  iter_flag     in   1              grid step-complete flag (iterFlag of the grid)
//  start         in   1              level; rising into IDLE begins a run
//  tap_row       in   $clog2(SIZE)   tap row, latched at start
//  tap_col       in   $clog2(SIZE)   tap column, latched at start
//  num_samples   in   CNT_W          samples per run, latched at start
//  sample_data   out  16s            audio word, valid with sample_valid
//  sample_valid  out  1              FIFO non-empty
//  sample_ready  in   1              consumer accepts when valid&ready
//  busy          out  1              state==RUN
//  done          out  1              state==DONE
//  overflow      out  1              sticky: >=1 sample dropped this run
//  sample_count  out  CNT_W          step edges captured this run
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, iter_flag_d=0.
//  FSM: IDLE -start-> RUN (latch tap_row/col, num_samples; clear sample_count, overflow);
//   num_samples==0 -> DONE directly. RUN -(sample_count==num_samples)-> DONE. DONE -!start-> IDLE.
//   start ignored in RUN/DONE.
//  Step edge = iter_flag & ~iter_flag_d (iter_flag_d registered every cycle). Only edges in RUN count.
//  On edge in cycle N: read u_2_mid[tap_row_q][tap_col_q] same cycle; tap indices >=SIZE clamp to SIZE-1.
//   sample_count increments. FIFO push; sample_valid high by N+1 if FIFO was empty.
//  Conversion: sample_data = u[17:2] (truncation, no rounding).
//  FIFO full on edge: push accepted only if a pop happens the same cycle; otherwise the sample is dropped,
//   overflow set, and sample_count still increments.
//  Handshake: pop on sample_valid & sample_ready. sample_data must stay stable while valid & ~ready.
//   sample_valid never depends combinationally on sample_ready.
//  FIFO is not flushed on DONE or IDLE. The consumer may drain it after the run. A new run clears only
//   the counters and overflow.
//  Reset mid-run: everything clears immediately, and buffered samples are lost.
// CONFIGURATION
//  DRUM_TAP_GAIN_EN defined:
//   - extra input tap_gain [2:0], latched at start.
//   - word = sat16((u >>> 2) <<< gain), clamped to +32767/-32768.
//   - conversion adds one register stage: push happens at N+1, sample_valid by N+2.
//  Undefined: no tap_gain port; truncation path with the latency given above.
// STRUCTURE
//  Package drum_pkg:
//   - typedef node_t (logic signed [17:0]), typedef audio_t (logic signed [15:0])
//   - enum tap_state_t {IDLE,RUN,DONE}
//   - localparam AUDIO_SHIFT=2
//  Sub-module tap_sample_fifo: sync show-ahead FIFO, DEPTH/width params, push/pop/full/empty,
//   simultaneous push+pop allowed when full.
// TESTING
//  1 SIZE=4, tap(1,2), num_samples=3, u[1][2]=18'h1_0004, ready=1, three iter_flag pulses ->
//    words 16'h4001 x3, then done=1, overflow=0, sample_count=3.
//  2 num_samples=0, start -> done=1 next cycle, no sample_valid.
//  3 ready=0, 10 step edges, DEPTH=8 -> 8 buffered, overflow=1, sample_count=10.
//    Release ready -> first 8 captured values in order.
//  4 iter_flag held high 5 cycles -> exactly one sample. Edge while FIFO full and popping -> no drop.
//  5 reset asserted mid-run with 3 buffered -> same cycle: valid=0, busy=0, count=0.
//  6 GAIN_EN, gain=3, u=18'h1_FFFC -> 16'h7FFF (saturated). u=-4 -> 16'hFFF8.

Source files
------------

// File: rtl/drum_tap_streamer_pkg.sv
// Shared types and sample conversion helpers for the drum tap streamer.
package drum_pkg;

  typedef logic signed [17:0] node_t;
  typedef logic signed [15:0] audio_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tap_state_t;

  localparam int unsigned AUDIO_SHIFT = 2;

  function automatic audio_t to_audio_trunc(input node_t u);
    return u[AUDIO_SHIFT +: 16];
  endfunction

  // The node is widened before the gain shift so that saturation can see the overflowed magnitude.
  function automatic audio_t to_audio_gain(input node_t u, input logic [2:0] gain);
    logic signed [23:0] w;
    w = {{6{u[17]}}, u};
    w = w >>> AUDIO_SHIFT;
    w = w <<< gain;
    if (w > 24'sd32767) begin
      return 16'sh7FFF;
    end else if (w < -24'sd32768) begin
      return 16'sh8000;
    end else begin
      return w[15:0];
    end
  endfunction

endpackage

// File: rtl/drum_tap_streamer_if.sv
// Valid/ready audio sample stream between the tap streamer and the audio output path.
interface drum_tap_streamer_if;

  drum_pkg::audio_t sample_data;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/drum_tap_streamer_fifo.sv
// Synchronous show-ahead sample FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module tap_sample_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/drum_tap_streamer.sv
// Samples one grid tap node per step edge, buffers the audio words and streams them out.
// Optional DRUM_TAP_GAIN_EN adds a latched tap_gain input and a saturating, registered gain stage.
module drum_tap_streamer
  import drum_pkg::*;
#(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  node_t                   u_2_mid [SIZE-1:0][SIZE-1:0],
  input  logic                    iter_flag,
  input  logic                    start,
  input  logic [$clog2(SIZE)-1:0] tap_row,
  input  logic [$clog2(SIZE)-1:0] tap_col,
  input  logic [CNT_W-1:0]        num_samples,
`ifdef DRUM_TAP_GAIN_EN
  input  logic [2:0]              tap_gain,
`endif
  drum_tap_streamer_if.master     stream,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [CNT_W-1:0]        sample_count
);

  localparam int unsigned IDX_W = $clog2(SIZE);
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(SIZE - 1);

  tap_state_t       r_state;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;
  logic             r_iter_d;

  logic [IDX_W-1:0] w_row_clamp;
  logic [IDX_W-1:0] w_col_clamp;
  node_t            w_node;
  logic             w_edge;
  logic             w_take;
  logic             w_push;
  audio_t           w_push_data;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  audio_t           w_pop_data;
  logic             w_drop;

  assign w_row_clamp = ({1'b0, tap_row} > LAST_IDX) ? LAST_IDX[IDX_W-1:0] : tap_row;
  assign w_col_clamp = ({1'b0, tap_col} > LAST_IDX) ? LAST_IDX[IDX_W-1:0] : tap_col;

  assign w_node = u_2_mid[r_row][r_col];
  assign w_edge = iter_flag & ~r_iter_d;
  assign w_take = w_edge & (r_state == RUN) & (r_count != r_num);

`ifdef DRUM_TAP_GAIN_EN
  logic [2:0] r_gain;
  logic       r_conv_vld;
  audio_t     r_conv_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gain      <= '0;
      r_conv_vld  <= 1'b0;
      r_conv_data <= '0;
    end else begin
      if (r_state == IDLE && start) r_gain <= tap_gain;
      r_conv_vld  <= w_take;
      r_conv_data <= to_audio_gain(w_node, r_gain);
    end
  end

  assign w_push      = r_conv_vld;
  assign w_push_data = r_conv_data;
`else
  assign w_push      = w_take;
  assign w_push_data = to_audio_trunc(w_node);
`endif

  assign w_pop  = stream.sample_valid & stream.sample_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iter_d <= 1'b0;
    end else begin
      r_iter_d <= iter_flag;
    end
  end

  // Drop flagging precedes the case so a run start clears overflow with priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_num      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_row      <= w_row_clamp;
            r_col      <= w_col_clamp;
            r_num      <= num_samples;
            r_count    <= '0;
            r_overflow <= 1'b0;
            if (num_samples == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (r_count == r_num) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_take) begin
            r_count <= r_count + 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  tap_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign stream.sample_valid = ~w_empty;
  assign stream.sample_data  = w_pop_data;
  assign busy                = r_busy;
  assign done                = r_done;
  assign overflow            = r_overflow;
  assign sample_count        = r_count;

endmodule

// File: tb/tb_drum_tap_streamer.sv
// Directed testbench for drum_tap_streamer; expected words are hand-computed from the tap node values.
module tb_drum_tap_streamer;
  import drum_pkg::*;

  logic        clock;
  logic        reset;
  node_t       u_2_mid [3:0][3:0];
  logic        iter_flag;
  logic        start;
  logic [1:0]  tap_row;
  logic [1:0]  tap_col;
  logic [15:0] num_samples;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] sample_count;
`ifdef DRUM_TAP_GAIN_EN
  logic [2:0]  tap_gain;
`endif

  drum_tap_streamer_if bus ();

  drum_tap_streamer #(
    .SIZE       (4),
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .u_2_mid      (u_2_mid),
    .iter_flag    (iter_flag),
    .start        (start),
    .tap_row      (tap_row),
    .tap_col      (tap_col),
    .num_samples  (num_samples),
`ifdef DRUM_TAP_GAIN_EN
    .tap_gain     (tap_gain),
`endif
    .stream       (bus.master),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .sample_count (sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int     n_checks = 0;
  int     n_errors = 0;
  audio_t rx_q [$];

  always @(negedge clock) begin
    if (!reset && bus.sample_valid && bus.sample_ready) rx_q.push_back(bus.sample_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    iter_flag = 1'b1;
    tick();
    iter_flag = 1'b0;
    tick();
  endtask

  task automatic set_tap(input node_t v);
    u_2_mid[1][2] = v;
  endtask

  initial begin
    reset       = 1'b1;
    iter_flag   = 1'b0;
    start       = 1'b0;
    tap_row     = 2'd1;
    tap_col     = 2'd2;
    num_samples = '0;
    bus.sample_ready = 1'b0;
`ifdef DRUM_TAP_GAIN_EN
    tap_gain    = 3'd0;
`endif
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        u_2_mid[r][c] = 18'(r * 16 + c + 100);
    tick(2);
    reset = 1'b0;
    tick();
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);

    // Test 1: three samples of u[1][2]=0x10004 -> 0x4001 each
    set_tap(18'h1_0004);
    bus.sample_ready = 1'b1;
    num_samples = 16'd3;
    start = 1'b1;
    tick();
    check("t1_busy", 32'(busy), 32'd1);
    repeat (3) pulse();
    tick(4);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_count", 32'(sample_count), 32'd3);
    check("t1_nwords", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("t1_word", 32'(rx_q[i]), 32'h4001);
    start = 1'b0;
    tick();
    check("t1_idle", 32'(done), 32'd0);
    rx_q.delete();

    // Test 2: zero-length run goes straight to DONE
    num_samples = 16'd0;
    start = 1'b1;
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_valid", 32'(bus.sample_valid), 32'd0);
    pulse();
    check("t2_count", 32'(sample_count), 32'd0);
    check("t2_nwords", 32'(rx_q.size()), 32'd0);
    start = 1'b0;
    tick();

    // Test 3: consumer stalled, 10 edges into an 8-deep buffer
    bus.sample_ready = 1'b0;
    num_samples = 16'd10;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      set_tap(18'(k * 4));
      pulse();
    end
    tick(3);
    check("t3_valid", 32'(bus.sample_valid), 32'd1);
    check("t3_head", 32'(bus.sample_data), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_count", 32'(sample_count), 32'd10);
    check("t3_done", 32'(done), 32'd1);
    bus.sample_ready = 1'b1;
    tick(12);
    check("t3_nwords", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t3_word", 32'(rx_q[i]), 32'(i + 1));
    check("t3_empty", 32'(bus.sample_valid), 32'd0);
    start = 1'b0;
    tick();
    rx_q.delete();

    // Test 4: held flag gives one sample; edge on a full-but-popping FIFO is kept
    num_samples = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_tap(18'(77 * 4));
    iter_flag = 1'b1;
    tick(5);
    iter_flag = 1'b0;
    tick(4);
    check("t4_held_count", 32'(sample_count), 32'd1);
    check("t4_held_nwords", 32'(rx_q.size()), 32'd1);
    check("t4_held_word", 32'(rx_q[0]), 32'd77);
    rx_q.delete();
    bus.sample_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      set_tap(18'(k * 4));
      pulse();
    end
    tick(2);
    check("t4_full_ovf", 32'(overflow), 32'd0);
    set_tap(18'(9 * 4));
    bus.sample_ready = 1'b1;
    iter_flag = 1'b1;
    tick();
    iter_flag = 1'b0;
    tick(12);
    check("t4_ovf", 32'(overflow), 32'd0);
    check("t4_count", 32'(sample_count), 32'd10);
    check("t4_nwords", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) check("t4_word", 32'(rx_q[i]), 32'(i + 1));
    rx_q.delete();

    // Test 5: asynchronous reset mid-run with buffered samples
    bus.sample_ready = 1'b0;
    repeat (3) pulse();
    tick(2);
    check("t5_pre_valid", 32'(bus.sample_valid), 32'd1);
    check("t5_pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_valid", 32'(bus.sample_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_count", 32'(sample_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_after_valid", 32'(bus.sample_valid), 32'd0);

`ifdef DRUM_TAP_GAIN_EN
    // Test 6: gain 3 saturates a large positive node and scales -4 to -8
    tap_gain = 3'd3;
    num_samples = 16'd2;
    bus.sample_ready = 1'b0;
    start = 1'b1;
    tick();
    set_tap(18'h1_FFFC);
    pulse();
    set_tap(-18'sd4);
    pulse();
    tick(3);
    check("t6_head", 32'(bus.sample_data), 32'h7FFF);
    bus.sample_ready = 1'b1;
    tick(4);
    check("t6_nwords", 32'(rx_q.size()), 32'd2);
    check("t6_sat", 32'(rx_q[0]), 32'h7FFF);
    check("t6_neg", 32'(rx_q[1]), 32'hFFF8);
    start = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
